// File: rtl/tdm_mux8_tx.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mux8_tx
// Purpose  : Time-division serializer feeding a 1-to-N_CH demultiplexer.
//            Accepts one N_CH-bit word over valid/ready, then emits it one
//            bit per cycle on out, with ctrl naming the destination channel
//            and en qualifying each bit. done pulses with the last bit.
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in_data   - parallel word to serialize
//            in_valid  - in_data valid
//            in_ready  - block can accept a word (IDLE)
//            hold      - pause request, freezes the frame in place
//            out       - serial data bit for the current channel
//            ctrl      - channel index of out
//            en        - out/ctrl valid this cycle
//            done      - one-cycle pulse with the last bit of a frame
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mux8_tx #(
    parameter int N_CH      = 8,
    parameter int SEL_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             out,
    output logic [SEL_W-1:0] ctrl,
    output logic             en,
    output logic             done
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    // Channel walk endpoints depend on bit order.
    localparam logic [SEL_W-1:0] c_FIRST = (MSB_FIRST != 0) ? SEL_W'(N_CH - 1) : '0;
    localparam logic [SEL_W-1:0] c_LAST  = (MSB_FIRST != 0) ? '0 : SEL_W'(N_CH - 1);

    logic [0:0]       r_state;
    logic [N_CH-1:0]  r_word;
    logic [SEL_W-1:0] r_idx;

    logic [0:0]       w_state_nxt;
    logic [N_CH-1:0]  w_word_nxt;
    logic [SEL_W-1:0] w_idx_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_IDLE: begin
                // in_ready is implied by being in IDLE.
                if (in_valid) begin
                    w_word_nxt  = in_data;
                    w_idx_nxt   = c_FIRST;
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                // hold freezes state, word and index entirely.
                if (!hold) begin
                    if (r_idx == c_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_idx_nxt   = '0;
                    end else if (MSB_FIRST != 0) begin
                        w_idx_nxt = r_idx - SEL_W'(1);
                    end else begin
                        w_idx_nxt = r_idx + SEL_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: registered state plus hold only, so in_data and
    // in_valid never reach the outputs combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        en       = 1'b0;
        ctrl     = '0;
        out      = 1'b0;
        done     = 1'b0;
        if (r_state == c_IDLE) begin
            in_ready = 1'b1;
        end else begin
            // ctrl/out stay visible during hold; only en/done drop.
            en   = ~hold;
            ctrl = r_idx;
            out  = r_word[r_idx];
            done = ~hold & (r_idx == c_LAST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux8_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mux8_tx
// Purpose  : Directed self-checking bench for tdm_mux8_tx. One instance in
//            LSB-first order, one in MSB-first order, plus a behavioural
//            1-to-8 demux with per-channel capture for the loopback check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mux8_tx;

    logic       clk;
    logic       rst_n;

    // LSB-first instance
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       hold;
    logic       out;
    logic [2:0] ctrl;
    logic       en;
    logic       done;

    // MSB-first instance
    logic [7:0] m_in_data;
    logic       m_in_valid;
    logic       m_in_ready;
    logic       m_hold;
    logic       m_out;
    logic [2:0] m_ctrl;
    logic       m_en;
    logic       m_done;

    logic [7:0] cap;

    int n_chk  = 0;
    int n_fail = 0;

    tdm_mux8_tx #(.N_CH(8), .SEL_W(3), .MSB_FIRST(0)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .hold     (hold),
        .out      (out),
        .ctrl     (ctrl),
        .en       (en),
        .done     (done)
    );

    tdm_mux8_tx #(.N_CH(8), .SEL_W(3), .MSB_FIRST(1)) u_dut_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (m_in_data),
        .in_valid (m_in_valid),
        .in_ready (m_in_ready),
        .hold     (m_hold),
        .out      (m_out),
        .ctrl     (m_ctrl),
        .en       (m_en),
        .done     (m_done)
    );

    // Behavioural 1-to-8 demux with per-channel capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap <= '0;
        else if (en) cap[ctrl] <= out;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_data = '0; in_valid = 1'b0; hold = 1'b0;
        m_in_data = '0; m_in_valid = 1'b0; m_hold = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, en, out, ctrl, done} !== 7'b1_0_0_000_0) begin
            n_fail++;
            $display("FAIL reset_immediate: got rdy/en/out/ctrl/done=%b%b%b_%b_%b want 100_000_0",
                     in_ready, en, out, ctrl, done);
        end
        n_chk++;
        if ({m_in_ready, m_en, m_out, m_ctrl, m_done} !== 7'b1_0_0_000_0) begin
            n_fail++;
            $display("FAIL reset_immediate_msb: got %b%b%b_%b_%b want 100_000_0",
                     m_in_ready, m_en, m_out, m_ctrl, m_done);
        end
        step(); step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({in_ready, en, out, ctrl, done} !== 7'b1_0_0_000_0) begin
                n_fail++;
                $display("FAIL reset_idle_%0d: got %b%b%b_%b_%b want 100_000_0",
                         i, in_ready, en, out, ctrl, done);
            end
        end
    endtask

    task automatic test_single_frame();
        bit exp_out [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if ({en, ctrl, out, done, in_ready} !== {1'b1, 3'(i), exp_out[i], (i == 7), 1'b0}) begin
                n_fail++;
                $display("FAIL frame_a5_bit%0d: got en=%b ctrl=%0d out=%b done=%b rdy=%b want en=1 ctrl=%0d out=%b done=%b rdy=0",
                         i, en, ctrl, out, done, in_ready, i, exp_out[i], (i == 7));
            end
            step();
        end
        n_chk++;
        if ({in_ready, en, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL frame_a5_after: got rdy/en/done=%b%b%b want 100", in_ready, en, done);
        end
    endtask

    task automatic test_hold();
        bit exp_out [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        int n_done  = 0;
        int n_shift = 0;
        in_data = 8'h3C; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_shift++; if (done) n_done++;
            step();
        end
        hold = 1'b1;
        #1;
        for (int h = 0; h < 2; h++) begin
            n_chk++;
            if ({en, ctrl, out, done} !== {1'b0, 3'd3, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got en=%b ctrl=%0d out=%b done=%b want en=0 ctrl=3 out=1 done=0",
                         h, en, ctrl, out, done);
            end
            n_shift++; if (done) n_done++;
            step();
        end
        hold = 1'b0;
        #1;
        for (int i = 3; i < 8; i++) begin
            n_chk++;
            if ({en, ctrl, out} !== {1'b1, 3'(i), exp_out[i]}) begin
                n_fail++;
                $display("FAIL hold_resume_ch%0d: got en=%b ctrl=%0d out=%b want en=1 ctrl=%0d out=%b",
                         i, en, ctrl, out, i, exp_out[i]);
            end
            n_shift++; if (done) n_done++;
            step();
        end
        n_chk++;
        if (n_shift !== 10 || n_done !== 1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_totals: got shift=%0d done=%0d rdy=%b want shift=10 done=1 rdy=1",
                     n_shift, n_done, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_out [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_data = 8'h01;  // producer's next word waits while busy
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if ({in_ready, en, out, done} !== {1'b0, 1'b1, 1'b1, (i == 7)}) begin
                n_fail++;
                $display("FAIL b2b_ff_bit%0d: got rdy=%b en=%b out=%b done=%b want rdy=0 en=1 out=1 done=%b",
                         i, in_ready, en, out, done, (i == 7));
            end
            step();
        end
        n_chk++;
        if ({in_ready, en} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_bubble: got rdy=%b en=%b want rdy=1 en=0", in_ready, en);
        end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if ({en, ctrl, out} !== {1'b1, 3'(i), exp_out[i]}) begin
                n_fail++;
                $display("FAIL b2b_01_bit%0d: got en=%b ctrl=%0d out=%b want en=1 ctrl=%0d out=%b",
                         i, en, ctrl, out, i, exp_out[i]);
            end
            step();
        end
    endtask

    task automatic test_msb_first();
        bit exp_out [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        m_in_data = 8'h81; m_in_valid = 1'b1;
        step();
        m_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if ({m_en, m_ctrl, m_out, m_done} !== {1'b1, 3'(7 - i), exp_out[i], (i == 7)}) begin
                n_fail++;
                $display("FAIL msb_bit%0d: got en=%b ctrl=%0d out=%b done=%b want en=1 ctrl=%0d out=%b done=%b",
                         i, m_en, m_ctrl, m_out, m_done, 7 - i, exp_out[i], (i == 7));
            end
            step();
        end
        n_chk++;
        if ({m_in_ready, m_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL msb_after: got rdy=%b en=%b want rdy=1 en=0", m_in_ready, m_en);
        end
    endtask

    task automatic test_reset_midframe_loopback();
        int n_done = 0;
        in_data = 8'hC3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) n_done++;
            step();
        end
        n_chk++;
        if (ctrl !== 3'd4) begin
            n_fail++;
            $display("FAIL abort_pre_ctrl: got ctrl=%0d want 4", ctrl);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({en, done, in_ready, ctrl, out} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_immediate: got en=%b done=%b rdy=%b ctrl=%0d out=%b want 0 0 1 0 0",
                     en, done, in_ready, ctrl, out);
        end
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || en) n_done++;
        end
        n_chk++;
        if (n_done !== 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done: got done/en count=%0d rdy=%b want 0 rdy=1", n_done, in_ready);
        end
        // hold asserted in IDLE must not block acceptance
        hold = 1'b1;
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        hold = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 9; i++) step();
        n_chk++;
        if (cap !== 8'h5A) begin
            n_fail++;
            $display("FAIL loopback_capture: got %h want 5a", cap);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_hold();
        test_back_to_back();
        test_msb_first();
        test_reset_midframe_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
